// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY receive-path helpers: ceil-log2 for sizing counters/pointers
// and the default symbol widths (8-bit bytes, 10-bit raw 8b/10b symbols).
package pcie_phy_pkg;

    localparam int SYM_W_8B  = 8;
    localparam int SYM_W_10B = 10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO, head word always visible on head_dat_o; push->visible latency 1.
// Pop on empty is ignored; push on full is ignored unless a pop frees the slot in the same cycle.
module fifo_sync_param
    import pcie_phy_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/demux_packer_param.sv
// Packs RATIO IN_W-bit symbols into one word (first symbol in MSBs), optional idle-cycle flush of partial words.
// Latency 1 from last symbol to data_out when FIFO empty; only the word-completing symbol or a pending flush stalls ready_in.
module demux_packer_param
    import pcie_phy_pkg::*;
#(
    parameter int IN_W     = SYM_W_8B,
    parameter int RATIO    = 4,
    parameter int DEPTH    = 2,
    parameter int FLUSH_EN = 1
) (
    input  logic                  clk_4f,
    input  logic                  reset_L,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      lane_en,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = clog2(RATIO);
    localparam int CW    = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);
    localparam logic [RATIO-1:0] ALL  = '1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0]       asm_q, asm_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   live_q;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [RATIO+OUT_W-1:0] push_dat, head_dat;
    logic                   push, pop, accept, flush_req, can_push;

    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_out;
    assign can_push  = !fifo_full || pop;
    // live_q keeps ready_in low until the first edge after reset release.
    assign ready_in  = live_q && !flush_pend_q &&
                       ((fifo_count < CW'(DEPTH)) || pop || (cnt_q != LAST));
    assign accept    = valid_in && ready_in;
    // A pending flush blocks ready_in, so it never coincides with an accept.
    assign flush_req = (FLUSH_EN != 0) && live_q && (cnt_q != '0) &&
                       (flush_pend_q || !valid_in);

    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_dat     = '0;
        if (accept) begin
            if (cnt_q == LAST) begin
                push     = 1'b1;
                push_dat = {ALL, asm_q[OUT_W-1:IN_W], data_in};
                cnt_d    = '0;
                asm_d    = '0;
            end else begin
                for (int l = 0; l < RATIO - 1; l++) begin
                    if (cnt_q == CNT_W'(l)) asm_d[(RATIO-l)*IN_W-1 -: IN_W] = data_in;
                end
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush_req) begin
            if (can_push) begin
                push         = 1'b1;
                push_dat     = {~(ALL >> cnt_q), asm_q};
                cnt_d        = '0;
                asm_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            flush_pend_q <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
            live_q       <= 1'b1;
        end
    end

    fifo_sync_param #(
        .WIDTH (OUT_W + RATIO),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_4f),
        .rst_ni     (reset_L),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign {lane_en, data_out} = head_dat;

endmodule
